cpu_divider: RTL and testbench
==============================

Name: cpu_divider

Overview:
- Multi-cycle iterative integer divider for the execute stage; covers the division that the single-cycle ALU does not implement.
- Accepts dividend and divisor on a valid/ready input handshake and returns quotient, remainder and flags on a valid/ready output handshake.
- Radix-2 restoring algorithm on magnitudes, with sign fix-up; one quotient bit per cycle.
- Signed or unsigned mode is selected per operation.

Parameters:
- WIDTH, 32, operand/result width; equals CPU word width; must be ≥ 2.
- CNT_W, $clog2(WIDTH), width of iteration counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  divider can accept a request (high only in IDLE and rst low).
- in_signed  in  1  1 = two's-complement divide, 0 = unsigned.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- out_valid  out  1  result present (high only in DONE).
- out_ready  in  1  consumer accepts result.
- out_quot  out  WIDTH  quotient.
- out_rem  out  WIDTH  remainder.
- out_flags  out  4  indexed by pkg_cpu flag enum (FlagZ, FlagC, FlagV, FlagN).

Behaviour:
- Reset values: state = IDLE; out_valid = 0; out_quot = 0; out_rem = 0; out_flags = 0; counter = 0; in_ready = 0 while rst is high.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch in_a, in_b and in_signed, then go to PREP. This clock edge is the accepting edge E0.
- PREP:
  - If in_b == 0, go to DONE with divide-by-zero results (see below).
  - Otherwise form magnitudes: negate an operand if in_signed and its MSB is set; record the quotient sign (sign_a ^ sign_b) and the remainder sign (sign_a).
  - Clear the partial remainder, load the dividend magnitude into the shift register, set counter = 0, go to ITER.
- ITER, one step per cycle:
  - trial = {partial_rem, dividend_msb} − divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After WIDTH steps (counter == WIDTH−1), go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (truncating division, remainder takes the dividend's sign).
  - Register the results and flags, go to DONE.
- DONE:
  - out_valid = 1; out_quot, out_rem and out_flags held stable.
  - On out_ready, go to IDLE.
  - No new request is accepted in the same cycle (in_ready = 0 in DONE).
- Latency:
  - Normal operation: out_valid rises after edge E0 + WIDTH + 2 (34 edges for WIDTH = 32).
  - Divide by zero: out_valid rises after edge E0 + 1.
- Divide by zero (either mode): quotient = all ones, remainder = dividend, FlagC = 1, FlagV = 0.
- Signed overflow (in_signed, in_a = 100…0, in_b = all ones): quotient = 100…0, remainder = 0, FlagV = 1. This falls out of the magnitude path; only the flag needs detection.
- Flags:
  - FlagN = quotient MSB.
  - FlagZ = (quotient == 0).
  - FlagC = divide-by-zero.
  - FlagV = signed overflow.
- The unsigned trial subtraction must not lose the carry: dividend 0xFFFFFFFF with divisor 1 must give quotient 0xFFFFFFFF.
- in_a and in_b are sampled only at E0; changes afterwards have no effect.
- in_valid while busy is ignored, because in_ready = 0.

Test Plan:
- Unsigned 100 / 7 -> after 34 edges: out_quot = 14, out_rem = 2, flags N = 0, Z = 0, C = 0, V = 0.
- Signed −7 / 2 (0xFFFFFFF9 / 2) -> out_quot = 0xFFFFFFFD, out_rem = 0xFFFFFFFF, N = 1; unsigned same operands -> out_quot = 0x7FFFFFFC, out_rem = 1.
- 0x1234 / 0 in both modes -> out_valid after 1 edge, out_quot = 0xFFFFFFFF, out_rem = 0x1234, C = 1; also 3 / 5 unsigned -> out_quot = 0, out_rem = 3, Z = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> out_quot = 0x80000000, out_rem = 0, V = 1, N = 1; unsigned 0xFFFFFFFF / 1 -> out_quot = 0xFFFFFFFF, out_rem = 0.
- Backpressure: hold out_ready low 10 cycles in DONE -> outputs stable, in_ready = 0, a request presented meanwhile is not taken; out_ready = 1 -> IDLE next edge, then the pending request is accepted.
- Assert rst for 1 cycle at ITER step 10 -> next cycle IDLE, out_valid = 0, outputs 0; a fresh 50 / 5 request then returns out_quot = 10, out_rem = 0 with normal latency.

Source files
------------

// File: rtl/cpu_divider.sv
// Multi-cycle radix-2 restoring integer divider with valid/ready handshakes.
// Works on operand magnitudes and fixes the signs afterwards. Produces one quotient bit per cycle.

module cpu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [3:0]       out_flags
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // PREP  | divide-by-zero check, operand magnitudes, result signs
  // ITER  | one restoring step per cycle, WIDTH steps
  // FIX   | sign fix-up, results and flags registered
  // DONE  | result held until out_ready

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

  // Bit positions of out_flags, same order as the pkg_cpu flag enum
  typedef enum logic [1:0] {FlagZ, FlagC, FlagV, FlagN} flag_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [WIDTH-1:0] prem_q, shift_q, dvs_q;
  logic             quot_neg_q, rem_neg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             sign_a, sign_b, div_zero, last_step, ovf;
  logic [WIDTH-1:0] mag_a, mag_b, quot_fix, rem_fix;
  logic [WIDTH:0]   trial;
  logic [3:0]       flags_fix, flags_dz;

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);

  assign sign_a    = signed_q & a_q[WIDTH-1];
  assign sign_b    = signed_q & b_q[WIDTH-1];
  assign mag_a     = sign_a ? -a_q : a_q;
  assign mag_b     = sign_b ? -b_q : b_q;
  assign div_zero  = (b_q == '0);
  assign last_step = (cnt_q == LAST_STEP);
  assign ovf       = signed_q & (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (b_q == '1);

  // One extra bit keeps the carry of the unsigned trial subtraction.
  assign trial    = {prem_q, shift_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quot_fix = quot_neg_q ? -shift_q : shift_q;
  assign rem_fix  = rem_neg_q ? -prem_q : prem_q;

  always_comb begin
    flags_fix        = '0;
    flags_fix[FlagZ] = (quot_fix == '0);
    flags_fix[FlagV] = ovf;
    flags_fix[FlagN] = quot_fix[WIDTH-1];
  end

  always_comb begin
    flags_dz        = '0;
    flags_dz[FlagC] = 1'b1;
    flags_dz[FlagN] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PREP;
      PREP:    state_nxt = div_zero ? DONE : ITER;
      ITER:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
      prem_q     <= '0;
      shift_q    <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= '0;
      out_quot   <= '0;
      out_rem    <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            signed_q <= in_signed;
          end
        end
        PREP: begin
          if (div_zero) begin
            out_quot  <= '1;
            out_rem   <= a_q;
            out_flags <= flags_dz;
          end else begin
            prem_q     <= '0;
            shift_q    <= mag_a;
            dvs_q      <= mag_b;
            quot_neg_q <= sign_a ^ sign_b;
            rem_neg_q  <= sign_a;
            cnt_q      <= '0;
          end
        end
        ITER: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          if (!trial[WIDTH]) prem_q <= trial[WIDTH-1:0];
          else               prem_q <= {prem_q[WIDTH-2:0], shift_q[WIDTH-1]};
          shift_q <= {shift_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          out_quot  <= quot_fix;
          out_rem   <= rem_fix;
          out_flags <= flags_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_divider.sv
// Randomized and directed bench for cpu_divider, checked against an arithmetic reference model.
// Expected flag bit order is {N, V, C, Z}.

module tb_cpu_divider;
  localparam int W   = 32;
  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_V = 2;
  localparam int F_N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_quot, out_rem;
  logic [3:0]   out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_quot (out_quot),
    .out_rem  (out_rem),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Truncating division from plain arithmetic; 64-bit math absorbs the MIN / -1 case.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic [3:0] f);
    longint sa, sb;
    f = '0;
    if (b == 0) begin
      q      = '1;
      r      = a;
      f[F_C] = 1'b1;
    end else if (s) begin
      sa     = longint'($signed(a));
      sb     = longint'($signed(b));
      q      = W'(sa / sb);
      r      = W'(sa % sb);
      f[F_V] = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      q = a / b;
      r = a % b;
    end
    f[F_N] = q[W-1];
    f[F_Z] = (q == 0);
  endfunction

  // Presents a request and returns just after the accepting edge; later input changes must be ignored.
  task automatic start_req(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic rdy;
    int   n = 0;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    do begin
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    chk("accepted", rdy, 1);
    #1;
    in_valid  = 1'($urandom_range(0, 1));
    in_signed = 1'($urandom_range(0, 1));
    in_a      = $urandom;
    in_b      = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    chk({tag, " latency"}, n, exp_lat);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic [3:0] f);
    chk({tag, " quot"}, out_quot, q);
    chk({tag, " rem"}, out_rem, r);
    chk({tag, " flags"}, {28'd0, out_flags}, {28'd0, f});
  endtask

  task automatic release_out(input int hold, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic [3:0] f);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold valid", out_valid, 1);
      check_out("hold", q, r, f);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release valid", out_valid, 0);
    chk("release ready", in_ready, 1);
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic [3:0] f,
                        input int hold, input string tag);
    start_req(s, a, b);
    wait_done((b == 0) ? 1 : W + 2, tag);
    check_out(tag, q, r, f);
    release_out(hold, q, r, f);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         s;
    logic [W-1:0] a, b, q, r;
    logic [3:0]   f;

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", out_valid, 0);
    chk("reset ready", in_ready, 0);
    check_out("reset", '0, '0, '0);
    rst = 1'b0;
    #1;
    chk("post-reset ready", in_ready, 1);

    run_op(1'b0, 32'd100,       32'd7,       32'd14,       32'd2,       4'b0000, 1, "u100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 0, "s_m7_2");
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC, 32'd1,       4'b0000, 0, "u_fff9_2");
    run_op(1'b1, 32'h1234,      32'd0,       32'hFFFF_FFFF, 32'h1234,    4'b1010, 2, "s_dz");
    run_op(1'b0, 32'h1234,      32'd0,       32'hFFFF_FFFF, 32'h1234,    4'b1010, 0, "u_dz");
    run_op(1'b0, 32'd3,         32'd5,       32'd0,        32'd3,       4'b0001, 0, "u3_5");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,    4'b1100, 0, "s_ovf");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0,       4'b1000, 0, "u_max_1");

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 3 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 14);
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 13 == 5) begin
        s = 1'b1;
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      ref_div(s, a, b, q, r, f);
      run_op(s, a, b, q, r, f, $urandom_range(0, 3), "rand");
    end

    // Backpressure: result held, a request presented meanwhile waits for IDLE.
    start_req(1'b0, 32'd1000, 32'd7);
    in_valid = 1'b0;
    wait_done(W + 2, "bp");
    check_out("bp", 32'd142, 32'd6, 4'b0000);
    in_signed = 1'b0;
    in_a      = 32'd40;
    in_b      = 32'd6;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      check_out("bp hold", 32'd142, 32'd6, 4'b0000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release valid", out_valid, 0);
    chk("bp release ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp pending taken", in_ready, 0);
    in_valid = 1'b0;
    wait_done(W + 2, "bp pending");
    check_out("bp pending", 32'd6, 32'd4, 4'b0000);
    release_out(0, 32'd6, 32'd4, 4'b0000);

    // Reset in the middle of the iteration phase.
    start_req(1'b0, 32'h0001_0000, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst valid", out_valid, 0);
    chk("midrst ready", in_ready, 0);
    check_out("midrst", '0, '0, '0);
    rst = 1'b0;
    #1;
    chk("midrst idle", in_ready, 1);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 4'b0000, 2, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
